// File: rtl/ysyx_22051468_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22051468_shift_pkg
// Brief    : Shared shift-op encodings, LorR polarity and data width for the
//            shared 64-bit barrel shifter and its arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_22051468_shift_pkg;

  localparam int DATA_W = 64;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;
  localparam logic [1:0] SHIFT_RSV = 2'b11;

  // LorR value that selects a left shift
  localparam logic SHIFT_LEFT = 1'b1;

  // Sign-extend a 32-bit word to the full datapath width
  function automatic logic [DATA_W-1:0] sext32(input logic [31:0] w);
    return {{(DATA_W-32){w[31]}}, w};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22051468_Shift_64.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22051468_Shift_64
// Brief    : Combinational 64-bit logarithmic barrel shifter; shamt bit k
//            enables the stage that shifts by 2^k.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22051468_Shift_64
  import ysyx_22051468_shift_pkg::*;
(
  input  logic [DATA_W-1:0] din,
  input  logic [5:0]        shamt,
  input  logic              LorR,
  input  logic              AorL,
  output logic [DATA_W-1:0] dout
);

  logic [6:0][DATA_W-1:0] w_stage;

  assign w_stage[0] = din;

  for (genvar k = 0; k < 6; k++) begin : g_stage
    localparam int c_dist = 1 << k;
    logic [DATA_W-1:0] w_shifted;

    // One fixed-distance shift; arithmetic right fills with the current MSB
    always_comb begin
      if (LorR == SHIFT_LEFT) begin
        w_shifted = w_stage[k] << c_dist;
      end else if (AorL) begin
        w_shifted = DATA_W'($signed(w_stage[k]) >>> c_dist);
      end else begin
        w_shifted = w_stage[k] >> c_dist;
      end
    end

    assign w_stage[k+1] = shamt[k] ? w_shifted : w_stage[k];
  end

  assign dout = w_stage[6];

endmodule
`default_nettype wire

// File: rtl/ysyx_22051468_shift_arb.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22051468_shift_arb
// Brief    : Round-robin two-requester front end for the shared barrel
//            shifter; decodes RV64 shift ops (incl. W forms) and registers
//            the result onto a single valid/ready response channel.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22051468_shift_arb
  import ysyx_22051468_shift_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  input  logic [5:0]        req_shamt0,
  input  logic [5:0]        req_shamt1,
  input  logic [1:0]        req_op0,
  input  logic [1:0]        req_op1,
  input  logic              req_word0,
  input  logic              req_word1,
  input  logic [TAG_W-1:0]  req_tag0,
  input  logic [TAG_W-1:0]  req_tag1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic [TAG_W-1:0]  rsp_tag
);

  logic              r_last;
  logic [1:0]        w_grant;
  logic              w_can_accept;
  logic              w_accept;
  logic              w_sel;
  logic [DATA_W-1:0] w_data;
  logic [5:0]        w_shamt;
  logic [1:0]        w_op;
  logic              w_word;
  logic [TAG_W-1:0]  w_tag;
  logic [DATA_W-1:0] w_operand;
  logic [5:0]        w_amount;
  logic              w_lorr;
  logic              w_aorl;
  logic [DATA_W-1:0] w_shift_out;
  logic [DATA_W-1:0] w_result;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    w_grant = 2'b00;
    case (req_valid)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
      default: w_grant = 2'b00;
    endcase
  end

  assign w_can_accept = (~rsp_valid | rsp_ready) & ~flush;
  assign req_ready    = w_grant & {2{w_can_accept}};
  assign w_accept     = |(req_valid & req_ready);
  assign w_sel        = w_grant[1];

  assign w_data  = w_sel ? req_data1  : req_data0;
  assign w_shamt = w_sel ? req_shamt1 : req_shamt0;
  assign w_op    = w_sel ? req_op1    : req_op0;
  assign w_word  = w_sel ? req_word1  : req_word0;
  assign w_tag   = w_sel ? req_tag1   : req_tag0;

  // Operand/amount conditioning and shifter control decode for the winner
  always_comb begin
    w_operand = w_data;
    w_amount  = w_shamt;
    w_lorr    = SHIFT_LEFT;
    w_aorl    = 1'b0;
    if (w_op == SHIFT_SRL || w_op == SHIFT_SRA) begin
      w_lorr = ~SHIFT_LEFT;
    end
    if (w_op == SHIFT_SRA) begin
      w_aorl = 1'b1;
    end
    if (w_word) begin
      w_amount = {1'b0, w_shamt[4:0]};
      if (w_op == SHIFT_SRA) begin
        w_operand = sext32(w_data[31:0]);
      end else begin
        w_operand = {32'b0, w_data[31:0]};
      end
    end
  end

  ysyx_22051468_Shift_64 u_shift (
    .din   (w_operand),
    .shamt (w_amount),
    .LorR  (w_lorr),
    .AorL  (w_aorl),
    .dout  (w_shift_out)
  );

  assign w_result = w_word ? sext32(w_shift_out[31:0]) : w_shift_out;

  // Response register and round-robin pointer; flush drops only the valid bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_tag   <= '0;
      r_last    <= 1'b1;
    end else if (flush) begin
      rsp_valid <= 1'b0;
    end else if (w_accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= w_result;
      rsp_id    <= w_sel;
      rsp_tag   <= w_tag;
      r_last    <= w_sel;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
